spi_pwm_reg_if: RTL
===================

Name: spi_pwm_reg_if

Overview:
SPI-slave register front-end feeding the 7-channel PWM generator. It samples the SPI pins (sclk, cs, mosi) in the system clock domain and decodes 16-bit frames into per-channel duty registers. It drives miso for register read-back. Its duty bus is the direct input of the PWM counter/comparator stage.

Parameters:
NUM_CH, 7, number of duty registers/PWM channels (1..127)
DUTY_W, 8, duty register width; fixed equal to the frame data field

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
sclk  in  1  SPI clock, asynchronous to clk, mode 0
cs  in  1  SPI chip select, active-low, asynchronous
mosi  in  1  SPI data in, MSB first
miso  out  1  SPI data out; 0 when not reading
duty  out  NUM_CH*DUTY_W  flat duty bus; channel k at [k*8+7:k*8]
wr_stb  out  1  one-clk pulse on each accepted write
wr_addr  out  7  address of last accepted write

Behaviour:
- Reset (async assert, sync release): duty=0, wr_stb=0, wr_addr=0, miso=0, bit counter=0, FSM=WAIT_CS.
- Synchronisers: sclk, cs and mosi each pass through 2 flops. Edge detect uses a third sclk flop. Rising/falling sclk events are single-clk pulses. clk must be at least 4x the sclk frequency.
- Frame (MSB first, 16 bits): bit15 = R/nW, where 0 = write and 1 = read. Bits14:8 = addr. Bits7:0 = data.
- FSM states:
  - WAIT_CS: go to IDLE when synced cs=1.
  - IDLE: go to SHIFT on synced cs=0; clear bit counter.
  - SHIFT: each rising-sclk event shifts synced mosi in and increments the counter. The 16th rise goes to DONE. cs=1 before 16 bits returns to IDLE and discards the partial frame; no write occurs.
  - DONE: go to IDLE on cs=1. Extra sclk edges in this state are ignored; there is no burst mode.
- Write:
  - Trigger: frame completes with bit15=0 and addr<NUM_CH.
  - Result: on the next clk edge, duty[addr] is updated, wr_addr=addr, and wr_stb=1 for exactly one cycle.
  - Latency: 1 clk after the 16th synced rising edge; 4 clk from the raw sclk rise.
  - addr>=NUM_CH: no register change and no strobe. The 0x7F exception is described under Optional Feature.
- Read:
  - Trigger: bit15=1 latched at the 8th rise.
  - Load: on the falling-sclk event after the 8th rise, the tx register is loaded with duty[addr] (0x00 if addr>=NUM_CH) and miso = its bit7.
  - Shift: each subsequent falling event shifts the next bit out.
  - Idle level: miso returns to 0 on cs=1, and at any time outside the read data phase.
  - Side effects: reads never modify registers and never pulse wr_stb.
- Simultaneous events: cs rising in the same clk as the 16th rise counts as a completed frame; the write is accepted.
- Reset mid-frame clears all state. A cs held low across reset release is ignored until cs goes high (WAIT_CS).

Optional Feature:
Macro PWM_SHADOW_EN.
- Defined:
  - Writes land in shadow registers.
  - duty outputs change only on a write frame to addr 0x7F (data ignored). That write copies all shadows to duty in one clk and pulses wr_stb with wr_addr=0x7F.
  - Reads return shadow values.
  - Reset clears both the shadow registers and duty.
- Undefined: writes go directly to duty as above, and addr 0x7F is an ordinary out-of-range address.

Decomposition:
Shared package spi_pwm_pkg holds:
- FRAME_W=16
- ADDR_W=7
- DATA_W=8
- COMMIT_ADDR=7'h7F
- RW_BIT=15
- FSM state enum (WAIT_CS, IDLE, SHIFT, DONE)

One sub-module, spi_sync_edge: a 2-flop synchroniser plus rise/fall pulse generator, instantiated for sclk. cs and mosi use a sync-only instance.

Test Plan:
- Write 0x0280 (ch2 <= 0x80), then cs high -> duty[23:16]=0x80, wr_stb one cycle, wr_addr=2, other channels 0.
- Write ch6=0xFF, then read frame 0x8600 -> miso shifts 1111_1111 during byte 2; miso=0 in byte 1 and after cs high.
- Raise cs after 10 bits of 0x0155 -> no wr_stb, duty[15:8] unchanged (0); the next full frame 0x0133 sets ch1=0x33.
- Write addr 0x10 data 0xAA -> no strobe, duty unchanged; read 0x9000 returns 0x00.
- Assert reset_n=0 mid-frame with cs low, release with cs still low, send 8 clocks, raise cs, send 0x0011 -> only ch0=0x11; all outputs 0 during reset.
- With PWM_SHADOW_EN: write ch0=0x40 -> duty[7:0] stays 0 and read returns 0x40; then write 0x7F00 -> duty[7:0]=0x40, wr_stb with wr_addr=0x7F.

Source files
------------

// File: rtl/spi_pwm_pkg.sv
// spi_pwm_pkg: shared frame layout constants and FSM state type for the
// SPI register front-end of the PWM generator.
package spi_pwm_pkg;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;
   localparam int RW_BIT  = 15;

   localparam logic [ADDR_W-1:0] COMMIT_ADDR = 7'h7F;

   typedef enum logic [1:0] {
      WAIT_CS = 2'd0,
      IDLE    = 2'd1,
      SHIFT   = 2'd2,
      DONE    = 2'd3
   } spi_state_t;

   // Address field of a complete frame.
   function automatic logic [ADDR_W-1:0] frame_addr(input logic [FRAME_W-1:0] f);
      return f[RW_BIT-1 -: ADDR_W];
   endfunction

   // Data field of a complete frame.
   function automatic logic [DATA_W-1:0] frame_data(input logic [FRAME_W-1:0] f);
      return f[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/spi_pwm_reg_if_if.sv
// spi_pwm_reg_if_if: SPI pin bundle. The master modport is the bus host
// (drives sclk/cs/mosi), the slave modport is the register front-end.
interface spi_pwm_reg_if_if;
   logic sclk;
   logic cs;
   logic mosi;
   logic miso;

   modport master (output sclk, output cs, output mosi, input miso);
   modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchroniser for W asynchronous inputs. With
// EDGE_EN set, a third flop provides registered single-clk rise/fall
// pulses; with EDGE_EN clear the edge outputs are tied low.
module spi_sync_edge #(
   parameter int W       = 1,
   parameter bit EDGE_EN = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] sync,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);

   logic [W-1:0] meta;
   logic [W-1:0] stable;

   // Two-stage metastability filter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta   <= '0;
         stable <= '0;
      end else begin
         meta   <= din;
         stable <= meta;
      end
   end

   assign sync = stable;

   generate
      if (EDGE_EN) begin : g_edge
         logic [W-1:0] last;
         logic [W-1:0] rise_r;
         logic [W-1:0] fall_r;

         // Delayed copy and registered edge pulses.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               last   <= '0;
               rise_r <= '0;
               fall_r <= '0;
            end else begin
               last   <= stable;
               rise_r <= stable & ~last;
               fall_r <= ~stable & last;
            end
         end

         assign rise = rise_r;
         assign fall = fall_r;
      end else begin : g_no_edge
         assign rise = '0;
         assign fall = '0;
      end
   endgenerate

endmodule

// File: rtl/spi_pwm_reg_if.sv
// spi_pwm_reg_if: SPI-slave (mode 0) register front-end for the PWM
// generator. 16-bit frames {R/nW, addr[6:0], data[7:0]} write or read the
// per-channel duty registers; miso returns read data in the second byte.
// Build option PWM_SHADOW_EN: writes land in shadow registers and a write
// to address 0x7F copies every shadow into the live duty bus at once.
module spi_pwm_reg_if
   import spi_pwm_pkg::*;
#(
   parameter int NUM_CH = 7,
   parameter int DUTY_W = DATA_W
) (
   input  logic                     clk,
   input  logic                     reset_n,
   spi_pwm_reg_if_if.slave          spi,
   output logic [NUM_CH*DUTY_W-1:0] duty,
   output logic                     wr_stb,
   output logic [ADDR_W-1:0]        wr_addr
);

   localparam logic [4:0] LAST_BIT = 5'(FRAME_W - 1);
   localparam logic [4:0] RD_BIT   = 5'(FRAME_W - DATA_W - 1);
   localparam logic [4:0] RD_LOAD  = 5'(FRAME_W - DATA_W);

   // Synchronised SPI pins
   logic sclk_lvl_unused;
   logic sclk_rise;
   logic sclk_fall;
   logic cs_s;
   logic mosi_s;
   logic [1:0] pin_rise_unused;
   logic [1:0] pin_fall_unused;

   spi_sync_edge #(.W(1), .EDGE_EN(1'b1)) u_sclk_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (spi.sclk),
      .sync    (sclk_lvl_unused),
      .rise    (sclk_rise),
      .fall    (sclk_fall)
   );

   spi_sync_edge #(.W(2), .EDGE_EN(1'b0)) u_pin_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     ({spi.cs, spi.mosi}),
      .sync    ({cs_s, mosi_s}),
      .rise    (pin_rise_unused),
      .fall    (pin_fall_unused)
   );

   // Frame engine state
   spi_state_t           state;
   logic [4:0]           bit_cnt;
   logic [FRAME_W-1:0]   sr;
   logic [FRAME_W-1:0]   next_sr;
   logic                 rd_pend;
   logic [ADDR_W-1:0]    rd_addr;
   logic [DATA_W-1:0]    tx;
   logic                 miso_r;
   logic [DUTY_W-1:0]    duty_r [NUM_CH];
`ifdef PWM_SHADOW_EN
   logic [DUTY_W-1:0]    shadow_r [NUM_CH];
`endif

   assign next_sr = {sr[FRAME_W-2:0], mosi_s};

   // Register lookup for read-back; out-of-range addresses read as zero.
   function automatic logic [DATA_W-1:0] reg_lookup(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (a == ADDR_W'(k)) begin
`ifdef PWM_SHADOW_EN
            v = shadow_r[k];
`else
            v = duty_r[k];
`endif
         end
      end
      return v;
   endfunction

   // Frame FSM, read shifter, register file and write strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= WAIT_CS;
         bit_cnt <= '0;
         sr      <= '0;
         rd_pend <= 1'b0;
         rd_addr <= '0;
         tx      <= '0;
         miso_r  <= 1'b0;
         wr_stb  <= 1'b0;
         wr_addr <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            duty_r[k] <= '0;
`ifdef PWM_SHADOW_EN
            shadow_r[k] <= '0;
`endif
         end
      end else begin
         wr_stb <= 1'b0;
         case (state)
            WAIT_CS: begin
               miso_r <= 1'b0;
               if (cs_s) state <= IDLE;
            end

            IDLE: begin
               miso_r  <= 1'b0;
               bit_cnt <= '0;
               rd_pend <= 1'b0;
               if (!cs_s) state <= SHIFT;
            end

            SHIFT: begin
               // A final rise wins over a simultaneous cs release.
               if (sclk_rise) begin
                  sr      <= next_sr;
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == RD_BIT && next_sr[DATA_W-1]) begin
                     rd_pend <= 1'b1;
                     rd_addr <= next_sr[ADDR_W-1:0];
                  end
                  if (bit_cnt == LAST_BIT) begin
                     state  <= DONE;
                     miso_r <= 1'b0;
                     if (!next_sr[RW_BIT]) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                           if (frame_addr(next_sr) == ADDR_W'(k)) begin
`ifdef PWM_SHADOW_EN
                              shadow_r[k] <= frame_data(next_sr);
`else
                              duty_r[k] <= frame_data(next_sr);
`endif
                           end
                        end
                        if (frame_addr(next_sr) < ADDR_W'(NUM_CH)) begin
                           wr_stb  <= 1'b1;
                           wr_addr <= frame_addr(next_sr);
                        end
`ifdef PWM_SHADOW_EN
                        else if (frame_addr(next_sr) == COMMIT_ADDR) begin
                           for (int k = 0; k < NUM_CH; k++) begin
                              duty_r[k] <= shadow_r[k];
                           end
                           wr_stb  <= 1'b1;
                           wr_addr <= COMMIT_ADDR;
                        end
`endif
                     end
                  end
               end else if (cs_s) begin
                  // Aborted frame: partial bits are dropped.
                  state  <= IDLE;
                  miso_r <= 1'b0;
               end else if (sclk_fall && rd_pend) begin
                  if (bit_cnt == RD_LOAD) begin
                     tx     <= reg_lookup(rd_addr);
                     miso_r <= reg_lookup(rd_addr)[DATA_W-1];
                  end else begin
                     tx     <= {tx[DATA_W-2:0], 1'b0};
                     miso_r <= tx[DATA_W-2];
                  end
               end
            end

            DONE: begin
               miso_r <= 1'b0;
               if (cs_s) state <= IDLE;
            end

            default: state <= WAIT_CS;
         endcase
      end
   end

   assign spi.miso = miso_r;

   generate
      for (genvar k = 0; k < NUM_CH; k++) begin : g_duty
         assign duty[k*DUTY_W +: DUTY_W] = duty_r[k];
      end
   endgenerate

endmodule
